rf_access_ctrl: RTL and testbench
=================================

// Module: rf_access_ctrl
// PURPOSE
//  Requester-side controller for the 32x32 register file (2 read ports, 1 write port).
//  Accepts issued instructions and drives Ard1/Ard2 to fetch two source operands.
//  Buffers operands, rd and WrRd for the execute stage.
//  Drives Awr/Din/WrEn from the writeback stage.
//  A busy-bit scoreboard blocks RAW/WAW hazards against outstanding writes.
// PARAMETERS
//  DATA_W       32  operand/data width, matches regfile Din/Dout
//  ADDR_W       5   register address width (32 regs, r0 hard-wired 0)
//  MAX_PENDING  4   max outstanding register writes; must be >=1 and <=31
// PORTS
//  Clk      in   1       clock, all state updates on rising edge
//  Rst_n    in   1       asynchronous active-low reset
//  IssValid in   1       issue request valid
//  IssReady out  1       issue accepted this cycle when IssValid&IssReady
//  IssRs1   in   ADDR_W  source register 1
//  IssRs2   in   ADDR_W  source register 2
//  IssRd    in   ADDR_W  destination register
//  IssWr    in   1       instruction writes IssRd
//  OpValid  out  1       operand buffer holds a valid entry
//  OpReady  in   1       execute stage consumes entry when OpValid&OpReady
//  OpA      out  DATA_W  operand from Rs1
//  OpB      out  DATA_W  operand from Rs2
//  OpRd     out  ADDR_W  destination register
//  OpWr     out  1       destination-write flag
//  WbValid  in   1       writeback valid; always accepted, no back-pressure
//  WbRd     in   ADDR_W  writeback register
//  WbData   in   DATA_W  writeback data
//  Ard1     out  ADDR_W  to regfile Ard1 (= IssRs1, combinational)
//  Ard2     out  ADDR_W  to regfile Ard2 (= IssRs2, combinational)
//  Dout1    in   DATA_W  from regfile Dout1
//  Dout2    in   DATA_W  from regfile Dout2
//  Awr      out  ADDR_W  to regfile Awr (= WbRd)
//  Din      out  DATA_W  to regfile Din (= WbData)
//  WrEn     out  1       to regfile WrEn (= WbValid && WbRd!=0)
//  PendCnt  out  3       outstanding writes; width = clog2(MAX_PENDING+1)
//  StallCnt out  16      cycles with IssValid&!IssReady; saturates at 16'hFFFF
// BEHAVIOUR
//  Reset: Busy[31:0]=0, PendCnt=0, StallCnt=0.
//   Outputs reset to OpValid=0, OpA=OpB=0, OpRd=0, OpWr=0.
//   Reset mid-operation discards the buffered entry and all pending state.
//  Operand buffer FSM:
//   EMPTY -> FULL on issue accept.
//   FULL -> EMPTY on OpReady with no new accept.
//   FULL -> FULL on simultaneous consume and accept.
//   OpValid=1 in FULL only.
//  Hazard: hz(r) = Busy[r] && r!=0.
//  IssReady = (EMPTY | OpReady) & !hz(Rs1) & !hz(Rs2)
//             & !(IssWr & hz(Rd)) & !(IssWr & IssRd!=0 & PendCnt==MAX_PENDING).
//  Accept: OpA<=Dout1, OpB<=Dout2, OpRd<=IssRd, OpWr<=IssWr at the same edge.
//   Latency issue->OpValid is 1 cycle.
//  Scoreboard set: on accept with IssWr & IssRd!=0,
//   Busy[IssRd]<=1 and PendCnt+1.
//  Scoreboard clear: on WbValid & WbRd!=0 & Busy[WbRd],
//   Busy[WbRd]<=0 and PendCnt-1.
//  Same-cycle set and clear on the same reg: set wins; PendCnt is net unchanged.
//  Writeback to a non-busy reg: regfile is written; no scoreboard change.
//  Writeback to r0: WrEn=0; ignored.
//  Without forwarding, a source reg cleared this cycle still stalls.
//   Issue proceeds next cycle and reads the updated regfile value.
//  IssRs1==IssRs2 is legal; both operands get the same value.
//  No combinational path from OpReady to Ard*, Awr, Din or WrEn.
// CONFIGURATION
//  RF_FORWARD_EN defined:
//   hz(r) excludes r when WbValid & WbRd==r & r!=0.
//   Matching operands take WbData instead of Dout1/Dout2.
//   Applies to Rs1, Rs2 and the WAW check on Rd.
//   This gives zero-bubble issue behind writeback.
//  RF_FORWARD_EN undefined: no bypass muxes; 1-cycle bubble per RAW on writeback.
// TESTING
//  1. Reset, issue Rs1=3,Rs2=4,Rd=5,Wr=1 (r3=0x11, r4=0x22):
//     next cycle OpValid=1, OpA=0x11, OpB=0x22, Busy[5]=1, PendCnt=1.
//  2. r5 busy, issue Rs1=5 while WbValid,WbRd=5,WbData=0xABCD:
//     no fwd -> IssReady=0 that cycle, accept next, OpA=0xABCD.
//     RF_FORWARD_EN -> accept same cycle, OpA=0xABCD.
//  3. Issue four writes Rd=1..4 with no writeback:
//     PendCnt=4; fifth write (Rd=6) has IssReady=0 and StallCnt increments.
//     A non-writing issue still proceeds.
//  4. OpReady=0, FULL, second issue pending:
//     IssReady=0, OpA/OpB held stable.
//     OpReady=1 -> consume and accept on the same edge, OpValid stays 1.
//  5. WbValid, WbRd=0, WbData=0xFFFF_FFFF:
//     WrEn=0; a read of r0 returns 0; PendCnt unchanged.
//  6. Assert Rst_n=0 mid-stall with PendCnt=2, FULL:
//     immediately OpValid=0, PendCnt=0, Busy=0, StallCnt=0.

Source files
------------

// File: rtl/rf_access_ctrl.sv
// rf_access_ctrl: requester-side controller for a 32x32 register file with
// two read ports and one write port. It drives Ard1/Ard2 from the issued
// instruction and captures the two operands, rd and the write flag in a
// one-entry buffer for the execute stage. It forwards writeback to the
// regfile write port. A busy-bit scoreboard holds off RAW and WAW hazards
// against writes that are still outstanding.
//
// Optional feature: define RF_FORWARD_EN to bypass same-cycle writeback data
// into the operand capture. This removes the one-cycle bubble that otherwise
// follows a RAW dependency on a register being written back.
module rf_access_ctrl #(
  parameter int  DATA_W      = 32,
  parameter int  ADDR_W      = 5,
  parameter int  MAX_PENDING = 4,
  localparam int CNT_W       = $clog2(MAX_PENDING + 1)
) (
  input  logic              Clk,
  input  logic              Rst_n,
  // issue side
  input  logic              IssValid,
  output logic              IssReady,
  input  logic [ADDR_W-1:0] IssRs1,
  input  logic [ADDR_W-1:0] IssRs2,
  input  logic [ADDR_W-1:0] IssRd,
  input  logic              IssWr,
  // operand buffer to execute
  output logic              OpValid,
  input  logic              OpReady,
  output logic [DATA_W-1:0] OpA,
  output logic [DATA_W-1:0] OpB,
  output logic [ADDR_W-1:0] OpRd,
  output logic              OpWr,
  // writeback
  input  logic              WbValid,
  input  logic [ADDR_W-1:0] WbRd,
  input  logic [DATA_W-1:0] WbData,
  // register file
  output logic [ADDR_W-1:0] Ard1,
  output logic [ADDR_W-1:0] Ard2,
  input  logic [DATA_W-1:0] Dout1,
  input  logic [DATA_W-1:0] Dout2,
  output logic [ADDR_W-1:0] Awr,
  output logic [DATA_W-1:0] Din,
  output logic              WrEn,
  // status
  output logic [CNT_W-1:0]  PendCnt,
  output logic [15:0]       StallCnt
);

  localparam int NREG = 1 << ADDR_W;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} buf_state_e;

  buf_state_e        state_q;
  logic              opvalid_q;
  logic [DATA_W-1:0] opa_q, opb_q;
  logic [ADDR_W-1:0] oprd_q;
  logic              opwr_q;

  logic [NREG-1:0]   busy_q, busy_d;
  logic [CNT_W-1:0]  pend_q, pend_d;
  logic [15:0]       stall_q, stall_d;

  logic              hz_rs1, hz_rs2, hz_rd;
  logic              pend_full, slot_free, accept;
  logic              sb_set, sb_clr;
  logic [DATA_W-1:0] opa_d, opb_d;

  // r0 is never busy; it is hard-wired to zero in the regfile.
  function automatic logic is_busy(input logic [NREG-1:0] busy,
                                   input logic [ADDR_W-1:0] r);
    return busy[r] && (r != '0);
  endfunction

  // Regfile ports: reads follow the issue slot, the write port follows writeback.
  assign Ard1 = IssRs1;
  assign Ard2 = IssRs2;
  assign Awr  = WbRd;
  assign Din  = WbData;
  assign WrEn = WbValid && (WbRd != '0);

`ifdef RF_FORWARD_EN
  logic fwd_rs1, fwd_rs2, fwd_rd;

  // A register being written back right now is treated as already available.
  assign fwd_rs1 = WbValid && (WbRd == IssRs1) && (IssRs1 != '0);
  assign fwd_rs2 = WbValid && (WbRd == IssRs2) && (IssRs2 != '0);
  assign fwd_rd  = WbValid && (WbRd == IssRd)  && (IssRd  != '0);

  assign hz_rs1 = is_busy(busy_q, IssRs1) && !fwd_rs1;
  assign hz_rs2 = is_busy(busy_q, IssRs2) && !fwd_rs2;
  assign hz_rd  = is_busy(busy_q, IssRd)  && !fwd_rd;
  assign opa_d  = fwd_rs1 ? WbData : Dout1;
  assign opb_d  = fwd_rs2 ? WbData : Dout2;
`else
  // Without bypass, a source cleared this cycle still stalls one cycle and
  // the issue then reads the freshly written regfile value.
  assign hz_rs1 = is_busy(busy_q, IssRs1);
  assign hz_rs2 = is_busy(busy_q, IssRs2);
  assign hz_rd  = is_busy(busy_q, IssRd);
  assign opa_d  = Dout1;
  assign opb_d  = Dout2;
`endif

  assign pend_full = (pend_q == CNT_W'(MAX_PENDING));
  assign slot_free = (state_q == EMPTY) || OpReady;
  assign IssReady  = slot_free && !hz_rs1 && !hz_rs2
                     && !(IssWr && hz_rd)
                     && !(IssWr && (IssRd != '0) && pend_full);
  assign accept    = IssValid && IssReady;

  assign sb_set = accept && IssWr && (IssRd != '0);
  assign sb_clr = WbValid && (WbRd != '0) && busy_q[WbRd];

  // Scoreboard next state: clear first so a same-register set wins.
  always_comb begin
    busy_d = busy_q;
    if (sb_clr) busy_d[WbRd] = 1'b0;
    if (sb_set) busy_d[IssRd] = 1'b1;
    pend_d  = pend_q + CNT_W'(sb_set) - CNT_W'(sb_clr);
    stall_d = stall_q;
    if (IssValid && !IssReady && (stall_q != 16'hFFFF)) stall_d = stall_q + 16'd1;
  end

  // Scoreboard, outstanding-write count and stall counter registers.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      busy_q  <= '0;
      pend_q  <= '0;
      stall_q <= '0;
    end else begin
      busy_q  <= busy_d;
      pend_q  <= pend_d;
      stall_q <= stall_d;
    end
  end

  // Operand buffer FSM with registered outputs; a consume and a new accept
  // on the same edge keep the buffer FULL.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q   <= EMPTY;
      opvalid_q <= 1'b0;
      opa_q     <= '0;
      opb_q     <= '0;
      oprd_q    <= '0;
      opwr_q    <= 1'b0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_q   <= FULL;
            opvalid_q <= 1'b1;
          end
        end
        FULL: begin
          if (!accept && OpReady) begin
            state_q   <= EMPTY;
            opvalid_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= EMPTY;
          opvalid_q <= 1'b0;
        end
      endcase
      if (accept) begin
        opa_q  <= opa_d;
        opb_q  <= opb_d;
        oprd_q <= IssRd;
        opwr_q <= IssWr;
      end
    end
  end

  assign OpValid  = opvalid_q;
  assign OpA      = opa_q;
  assign OpB      = opb_q;
  assign OpRd     = oprd_q;
  assign OpWr     = opwr_q;
  assign PendCnt  = pend_q;
  assign StallCnt = stall_q;

endmodule

// File: tb/tb_rf_access_ctrl.sv
// Testbench for rf_access_ctrl: a behavioural 32x32 regfile is attached, and
// a scoreboard queue holds the expected operand-buffer contents.
module tb_rf_access_ctrl;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int MAXP   = 4;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b1;
  logic        IssValid, IssReady, IssWr;
  logic [4:0]  IssRs1, IssRs2, IssRd;
  logic        OpValid, OpReady, OpWr;
  logic [31:0] OpA, OpB;
  logic [4:0]  OpRd;
  logic        WbValid;
  logic [4:0]  WbRd;
  logic [31:0] WbData;
  logic [4:0]  Ard1, Ard2, Awr;
  logic [31:0] Dout1, Dout2, Din;
  logic        WrEn;
  logic [2:0]  PendCnt;
  logic [15:0] StallCnt;

  rf_access_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_PENDING(MAXP)) dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .IssValid(IssValid), .IssReady(IssReady), .IssRs1(IssRs1), .IssRs2(IssRs2),
    .IssRd(IssRd), .IssWr(IssWr),
    .OpValid(OpValid), .OpReady(OpReady), .OpA(OpA), .OpB(OpB), .OpRd(OpRd), .OpWr(OpWr),
    .WbValid(WbValid), .WbRd(WbRd), .WbData(WbData),
    .Ard1(Ard1), .Ard2(Ard2), .Dout1(Dout1), .Dout2(Dout2),
    .Awr(Awr), .Din(Din), .WrEn(WrEn),
    .PendCnt(PendCnt), .StallCnt(StallCnt)
  );

  always #5 Clk = ~Clk;

  // Behavioural register file: asynchronous read, r0 reads as zero.
  logic [31:0] rf [32];
  assign Dout1 = (Ard1 == 5'd0) ? 32'd0 : rf[Ard1];
  assign Dout2 = (Ard2 == 5'd0) ? 32'd0 : rf[Ard2];
  always @(posedge Clk) if (WrEn) rf[Awr] <= Din;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        wr;
  } ent_t;

  ent_t        sb[$];
  logic [31:0] m_busy;
  int          m_pend, m_stall;
  logic        m_acc;
  int          n_vec, n_err;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic m_hz(input logic [4:0] r);
    logic h;
    h = m_busy[r] && (r != 5'd0);
`ifdef RF_FORWARD_EN
    if (WbValid && (WbRd == r)) h = 1'b0;
`endif
    return h;
  endfunction

  function automatic logic [31:0] m_rd(input logic [4:0] r);
    logic [31:0] v;
    v = (r == 5'd0) ? 32'd0 : rf[r];
`ifdef RF_FORWARD_EN
    if (WbValid && (WbRd == r) && (r != 5'd0)) v = WbData;
`endif
    return v;
  endfunction

  task automatic iss(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic [4:0] rd, input logic wr);
    IssValid = v; IssRs1 = rs1; IssRs2 = rs2; IssRd = rd; IssWr = wr;
  endtask

  task automatic wb(input logic v, input logic [4:0] rd, input logic [31:0] d);
    WbValid = v; WbRd = rd; WbData = d;
  endtask

  // One clock: compare outputs at the falling edge, advance the model, then
  // return just after the next rising edge so new inputs can be driven.
  task automatic step();
    logic rdy, set, clr;
    ent_t e;
    @(negedge Clk);
    rdy = ((sb.size() == 0) || OpReady) && !m_hz(IssRs1) && !m_hz(IssRs2)
          && !(IssWr && m_hz(IssRd))
          && !(IssWr && (IssRd != 5'd0) && (m_pend == MAXP));
    check("IssReady", IssReady, rdy);
    check("OpValid", OpValid, sb.size() != 0);
    if (sb.size() != 0) begin
      check("OpA", OpA, sb[0].a);
      check("OpB", OpB, sb[0].b);
      check("OpRd", OpRd, sb[0].rd);
      check("OpWr", OpWr, sb[0].wr);
    end
    check("PendCnt", PendCnt, m_pend);
    check("StallCnt", StallCnt, m_stall);
    check("WrEn", WrEn, WbValid && (WbRd != 5'd0));
    if (WbValid) begin
      check("Awr", Awr, WbRd);
      check("Din", Din, WbData);
    end
    check("Ard1", Ard1, IssRs1);
    check("Ard2", Ard2, IssRs2);
    m_acc = IssValid && rdy;
    if ((sb.size() != 0) && OpReady) void'(sb.pop_front());
    if (m_acc) begin
      e.a = m_rd(IssRs1); e.b = m_rd(IssRs2); e.rd = IssRd; e.wr = IssWr;
      sb.push_back(e);
    end
    set = m_acc && IssWr && (IssRd != 5'd0);
    clr = WbValid && (WbRd != 5'd0) && m_busy[WbRd];
    if (clr) m_busy[WbRd] = 1'b0;
    if (set) m_busy[IssRd] = 1'b1;
    m_pend = m_pend + int'(set) - int'(clr);
    if (IssValid && !rdy && (m_stall != 16'hFFFF)) m_stall++;
    @(posedge Clk);
    #1;
  endtask

  // Asynchronous reset asserted away from any clock edge; checked before the next edge.
  task automatic do_reset(input string tag);
    iss(0, 0, 0, 0, 0);
    wb(0, 0, 0);
    Rst_n = 1'b0;
    #1;
    check({tag, "_OpValid"}, OpValid, 0);
    check({tag, "_OpA"}, OpA, 0);
    check({tag, "_OpB"}, OpB, 0);
    check({tag, "_OpRd"}, OpRd, 0);
    check({tag, "_OpWr"}, OpWr, 0);
    check({tag, "_PendCnt"}, PendCnt, 0);
    check({tag, "_StallCnt"}, StallCnt, 0);
    sb.delete();
    m_busy = '0; m_pend = 0; m_stall = 0;
    @(negedge Clk);
    Rst_n = 1'b1;
    @(posedge Clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    n_vec = 0; n_err = 0;
    m_busy = '0; m_pend = 0; m_stall = 0; m_acc = 1'b0;
    for (int i = 0; i < 32; i++) rf[i] = 32'h1000 + i;
    rf[0] = 32'h0; rf[3] = 32'h11; rf[4] = 32'h22;
    OpReady = 1'b1;
    iss(0, 0, 0, 0, 0);
    wb(0, 0, 0);
    #2;
    do_reset("rst");

    // Basic issue: operands captured one cycle later, r5 becomes busy.
    iss(1, 3, 4, 5, 1);
    step();
    iss(0, 0, 0, 0, 0);
    check("t1_OpValid", OpValid, 1);
    check("t1_OpA", OpA, 32'h11);
    check("t1_OpB", OpB, 32'h22);
    check("t1_PendCnt", PendCnt, 1);
    step();

    // RAW on r5 while it is written back.
    iss(1, 5, 0, 7, 0);
    wb(1, 5, 32'hABCD);
    m_acc = 1'b0;
    for (int i = 0; i < 3 && !m_acc; i++) begin
      step();
      wb(0, 0, 0);
    end
    iss(0, 0, 0, 0, 0);
    check("t2_OpA", OpA, 32'hABCD);
    check("t2_PendCnt", PendCnt, 0);
    step();

    // Fill the outstanding-write limit, then stall a fifth write.
    for (int i = 1; i <= 4; i++) begin
      iss(1, 0, 0, 5'(i), 1);
      step();
    end
    iss(1, 0, 0, 6, 1);
    s0 = m_stall;
    step();
    step();
    check("t3_PendCnt", PendCnt, 4);
    check("t3_StallCnt", StallCnt, s0 + 2);
    iss(1, 0, 0, 6, 0);
    step();
    check("t3_nowr_OpValid", OpValid, 1);
    check("t3_nowr_OpWr", OpWr, 0);
    iss(0, 0, 0, 0, 0);
    for (int i = 1; i <= 4; i++) begin
      wb(1, 5'(i), 32'h100 + i);
      step();
    end
    wb(0, 0, 0);
    check("t3_drain_PendCnt", PendCnt, 0);

    // Back-pressure: buffer FULL, second issue held until consume.
    OpReady = 1'b0;
    iss(1, 1, 2, 8, 0);
    step();
    iss(1, 3, 4, 9, 0);
    step();
    step();
    check("t4_hold_OpA", OpA, 32'h101);
    check("t4_hold_OpB", OpB, 32'h102);
    OpReady = 1'b1;
    step();
    check("t4_OpValid", OpValid, 1);
    check("t4_OpA", OpA, 32'h103);
    check("t4_OpB", OpB, 32'h104);
    iss(0, 0, 0, 0, 0);
    step();

    // Writeback to r0 is ignored; r0 still reads zero.
    wb(1, 0, 32'hFFFF_FFFF);
    iss(1, 0, 0, 0, 1);
    #1;
    check("t5_WrEn", WrEn, 0);
    step();
    wb(0, 0, 0);
    iss(0, 0, 0, 0, 0);
    check("t5_OpA", OpA, 0);
    check("t5_PendCnt", PendCnt, 0);
    step();

    // Writeback to a non-busy register updates the regfile only.
    wb(1, 9, 32'h99);
    step();
    wb(0, 0, 0);
    iss(1, 9, 9, 0, 0);
    step();
    check("nb_OpA", OpA, 32'h99);
    check("nb_OpB", OpB, 32'h99);
    check("nb_PendCnt", PendCnt, 0);
    iss(0, 0, 0, 0, 0);
    step();

    // Random traffic on a small register window to provoke hazards.
    for (int n = 0; n < 300; n++) begin
      iss(($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
          5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      OpReady = ($urandom_range(0, 3) != 0);
      wb(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
      step();
    end
    iss(0, 0, 0, 0, 0);
    wb(0, 0, 0);
    OpReady = 1'b1;
    step();
    for (int r = 1; r < 8; r++) begin
      if (m_busy[r]) begin
        wb(1, 5'(r), 32'h500 + r);
        step();
      end
    end
    wb(0, 0, 0);
    step();
    check("rnd_drain_PendCnt", PendCnt, 0);

    // Reset mid-stall with two writes pending and the buffer FULL.
    iss(1, 0, 0, 10, 1);
    step();
    iss(1, 0, 0, 11, 1);
    step();
    OpReady = 1'b0;
    iss(1, 10, 0, 12, 0);
    step();
    check("t6_pre_PendCnt", PendCnt, 2);
    check("t6_pre_OpValid", OpValid, 1);
    #2;
    do_reset("t6");
    OpReady = 1'b1;
    iss(1, 10, 11, 10, 1);
    step();
    check("t6_post_OpValid", OpValid, 1);
    check("t6_post_PendCnt", PendCnt, 1);
    iss(0, 0, 0, 0, 0);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
